// File: rtl/redmule_zbuf_seq_if.sv
// Bundle between the Z buffer sequencer, the RedMulE engine output and the Z store streamer.
// Stream: a row transfers on a cycle where store_valid_o && store_ready_i at the rising clock edge.
// Once valid is raised it stays up, with data and strobe held, until that transfer completes.
interface redmule_zbuf_seq_if #(
  parameter int unsigned Depth = 8,
  parameter int unsigned DataW = 256,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) ();

  logic                 clk_en_i;
  logic                 fill_i;
  logic [DataW-1:0]     fill_data_i;
  logic [CntW-1:0]      rows_i;
  logic [DataW/8-1:0]   strb_i;
  logic                 full_o;
  logic                 empty_o;
  logic                 store_valid_o;
  logic                 store_ready_i;
  logic [DataW-1:0]     store_data_o;
  logic [DataW/8-1:0]   store_strb_o;
  logic                 overflow_o;

  // Drives the buffer: engine output, controller and streamer side.
  modport master (
    output clk_en_i,
    output fill_i,
    output fill_data_i,
    output rows_i,
    output strb_i,
    output store_ready_i,
    input  full_o,
    input  empty_o,
    input  store_valid_o,
    input  store_data_o,
    input  store_strb_o,
    input  overflow_o
  );

  // The buffer itself.
  modport slave (
    input  clk_en_i,
    input  fill_i,
    input  fill_data_i,
    input  rows_i,
    input  strb_i,
    input  store_ready_i,
    output full_o,
    output empty_o,
    output store_valid_o,
    output store_data_o,
    output store_strb_o,
    output overflow_o
  );

endinterface

// File: rtl/redmule_zbuf_seq.sv
// Z output buffer: collects one tile of computed Z rows, then drains them in order to the store streamer.
// dbg_state_o exposes the FSM state (0 = FILL, 1 = DRAIN).
module redmule_zbuf_seq #(
  parameter int unsigned Depth = 8,
  parameter int unsigned DataW = 256,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  redmule_zbuf_seq_if.slave        zbuf,
  output logic                     dbg_state_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned StrbW = DataW / 8;

  typedef enum logic {
    StFill  = 1'b0,
    StDrain = 1'b1
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   rows_q;
  logic [StrbW-1:0]  strb_q;
  logic [DataW-1:0]  mem_q [Depth];
  logic              overflow_q;

  logic              commit;
  logic [CntW-1:0]   rows_in;
  logic [CntW-1:0]   tile_rows;
  logic              wr_last;
  logic              rd_last;

  // The first row of a tile uses the row count sampled in the same cycle.
  always_comb begin
    commit    = zbuf.fill_i && zbuf.clk_en_i;
    rows_in   = (zbuf.rows_i == '0) ? CntW'(Depth) : zbuf.rows_i;
    tile_rows = (wr_ptr_q == '0) ? rows_in : rows_q;
    wr_last   = (CntW'(wr_ptr_q) == (tile_rows - CntW'(1)));
    rd_last   = (CntW'(rd_ptr_q) == (rows_q - CntW'(1)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rows_q     <= CntW'(Depth);
      strb_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      state_q    <= StFill;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rows_q     <= CntW'(Depth);
      strb_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StFill: begin
          if (commit) begin
            if (wr_ptr_q == '0) begin
              rows_q <= rows_in;
              strb_q <= zbuf.strb_i;
            end
            mem_q[wr_ptr_q] <= zbuf.fill_data_i;
            if (wr_last) begin
              state_q  <= StDrain;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
            end else begin
              wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
          end
        end
        StDrain: begin
          // Rows arriving mid-drain are dropped; the sticky flag records it.
          if (commit) begin
            overflow_q <= 1'b1;
          end
          if (zbuf.store_ready_i) begin
            if (rd_last) begin
              state_q  <= StFill;
              rd_ptr_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign zbuf.full_o        = (state_q == StDrain);
  assign zbuf.empty_o       = (state_q == StFill) && (wr_ptr_q == '0);
  assign zbuf.store_valid_o = (state_q == StDrain);
  assign zbuf.store_data_o  = mem_q[rd_ptr_q];
  assign zbuf.store_strb_o  = strb_q;
  assign zbuf.overflow_o    = overflow_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_redmule_zbuf_seq.sv
// Bench for redmule_zbuf_seq: directed tile scenarios plus random traffic against a queue-based tile model.
module tb_redmule_zbuf_seq;

  localparam int Depth = 8;
  localparam int DataW = 256;
  localparam int StrbW = DataW / 8;
  localparam int CntW  = $clog2(Depth + 1);

  // ---------------- clock / reset ----------------
  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;
  logic dbg_state;

  always #5 clk_i = ~clk_i;

  redmule_zbuf_seq_if #(.Depth(Depth), .DataW(DataW), .CntW(CntW)) zif ();

  redmule_zbuf_seq #(.Depth(Depth), .DataW(DataW), .CntW(CntW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .zbuf        (zif),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DataW-1:0] exp_q[$];   // rows of the tile currently held, oldest first
  logic [DataW-1:0] got_q[$];   // rows observed crossing the stream handshake
  int               m_rows;
  logic [StrbW-1:0] m_strb;
  bit               m_drain;
  bit               m_ovf;

  task automatic check(input string tag, input logic [DataW-1:0] act, input logic [DataW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rows  = Depth;
    m_strb  = '0;
    m_drain = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic compare_outputs();
    check("full",     zif.full_o,        m_drain);
    check("empty",    zif.empty_o,       (!m_drain && exp_q.size() == 0));
    check("valid",    zif.store_valid_o, m_drain);
    check("overflow", zif.overflow_o,    m_ovf);
    check("state",    dbg_state,         m_drain);
    if (m_drain) begin
      check("data", zif.store_data_o, exp_q[0]);
      check("strb", zif.store_strb_o, m_strb);
    end
  endtask

  function automatic logic [DataW-1:0] rnd_row();
    logic [DataW-1:0] r;
    for (int i = 0; i < DataW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle of inputs, advances the model, then checks.
  task automatic cycle(input bit fill, input logic [DataW-1:0] data, input int rows,
                       input logic [StrbW-1:0] strb, input bit en, input bit rdy, input bit clr);
    bit               pre_valid;
    logic [DataW-1:0] pre_data;
    logic [StrbW-1:0] pre_strb;
    zif.fill_i        = fill;
    zif.fill_data_i   = data;
    zif.rows_i        = CntW'(rows);
    zif.strb_i        = strb;
    zif.clk_en_i      = en;
    zif.store_ready_i = rdy;
    clear_i           = clr;
    pre_valid = zif.store_valid_o;
    pre_data  = zif.store_data_o;
    pre_strb  = zif.store_strb_o;
    if (pre_valid && rdy && !clr) got_q.push_back(pre_data);
    @(posedge clk_i);
    if (clr) begin
      model_reset();
    end else if (!m_drain) begin
      if (fill && en) begin
        if (exp_q.size() == 0) begin
          m_rows = (rows == 0) ? Depth : rows;
          m_strb = strb;
        end
        exp_q.push_back(data);
        if (exp_q.size() == m_rows) m_drain = 1'b1;
      end
    end else begin
      if (fill && en) m_ovf = 1'b1;
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_drain = 1'b0;
      end
    end
    #1;
    compare_outputs();
    if (pre_valid && !rdy && !clr) begin
      check("hold_valid", zif.store_valid_o, 1'b1);
      check("hold_data",  zif.store_data_o,  pre_data);
      check("hold_strb",  zif.store_strb_o,  pre_strb);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 0, '0, 1'b1, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               full_cnt;
    int               pat [7];
    logic [DataW-1:0] row;

    zif.fill_i = 1'b0; zif.fill_data_i = '0; zif.rows_i = '0; zif.strb_i = '0;
    zif.clk_en_i = 1'b1; zif.store_ready_i = 1'b0;
    model_reset();

    // Reset values, sampled while reset is held
    #12;
    check("rst_empty", zif.empty_o,       1'b1);
    check("rst_full",  zif.full_o,        1'b0);
    check("rst_valid", zif.store_valid_o, 1'b0);
    check("rst_ovf",   zif.overflow_o,    1'b0);
    check("rst_data",  zif.store_data_o,  '0);
    check("rst_strb",  zif.store_strb_o,  '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Full tile: rows_i=0 means Depth rows
    got_q.delete();
    for (int i = 1; i <= 8; i++) cycle(1'b1, DataW'(i), 0, '1, 1'b1, 1'b1, 1'b0);
    check("full_after_8th", zif.full_o, 1'b1);
    idle(8, 1'b1);
    check("full_empty_back", zif.empty_o, 1'b1);
    check("full_beats", got_q.size(), 8);
    for (int i = 0; i < got_q.size(); i++) check("full_row", got_q[i], DataW'(i + 1));
    idle(2, 1'b1);

    // Leftover tile with backpressure
    got_q.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, DataW'(32'h10 + i), 3, StrbW'(32'hFF), 1'b1, 1'b0, 1'b0);
    full_cnt = int'(zif.full_o);
    pat = '{1, 0, 0, 1, 1, 1, 1};
    for (int j = 0; j < 7; j++) begin
      cycle(1'b0, '0, 0, '0, 1'b1, pat[j][0], 1'b0);
      full_cnt += int'(zif.full_o);
    end
    check("lo_full_cycles", full_cnt, 5);
    check("lo_beats", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) check("lo_row", got_q[i], DataW'(32'h10 + i));

    // Single-row tile
    got_q.delete();
    cycle(1'b1, DataW'(8'hAB), 1, '1, 1'b1, 1'b0, 1'b0);
    check("one_full", zif.full_o, 1'b1);
    cycle(1'b0, '0, 0, '0, 1'b1, 1'b1, 1'b0);
    check("one_empty", zif.empty_o, 1'b1);
    check("one_beats", got_q.size(), 1);
    if (got_q.size() == 1) check("one_row", got_q[0], DataW'(8'hAB));

    // Clock-enable gating: fills with clk_en_i low are ignored
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DataW'(32'hDEAD), 2, '1, 1'b0, 1'b0, 1'b0);
      check("gate_empty", zif.empty_o, 1'b1);
    end

    // Overflow: a fill during DRAIN is dropped and flagged
    got_q.delete();
    cycle(1'b1, DataW'(32'h21), 2, StrbW'(32'h0F0F), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DataW'(32'h22), 2, StrbW'(32'h0F0F), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DataW'(32'hBAD), 2, '1, 1'b1, 1'b0, 1'b0);
    check("ovf_set", zif.overflow_o, 1'b1);
    idle(3, 1'b1);
    check("ovf_sticky", zif.overflow_o, 1'b1);
    check("ovf_beats", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check("ovf_row", got_q[i], DataW'(32'h21 + i));

    // Clear mid-drain, then a fresh 2-row tile
    for (int i = 0; i < 8; i++) cycle(1'b1, DataW'(32'h40 + i), 0, '1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, '0, 0, '0, 1'b1, 1'b0, 1'b1);
    check("clr_valid", zif.store_valid_o, 1'b0);
    check("clr_empty", zif.empty_o, 1'b1);
    check("clr_ovf",   zif.overflow_o, 1'b0);
    got_q.delete();
    cycle(1'b1, DataW'(32'h61), 2, StrbW'(32'h3), 1'b1, 1'b1, 1'b0);
    cycle(1'b1, DataW'(32'h62), 2, StrbW'(32'h3), 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("clr_beats", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check("clr_row", got_q[i], DataW'(32'h61 + i));

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      row = rnd_row();
      cycle(($urandom_range(0, 1) == 1), row, $urandom_range(0, Depth), StrbW'($urandom),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 6), ($urandom_range(0, 79) == 0));
    end

    // Asynchronous reset in the middle of a drain
    idle(Depth + 2, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_row(), 4, '1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, '0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", zif.store_valid_o, 1'b0);
    check("arst_empty", zif.empty_o, 1'b1);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
